// File: rtl/dcf77_pkg.sv
// Shared types and constants for the DCF77 frame controller and its frame checker.
package dcf77_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    RECEIVE   = 2'd1,
    CHECK     = 2'd2
  } state_t;

  localparam int FRAME_BITS = 59;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_SHORT    = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW = 3'd2;
  localparam logic [2:0] ERR_FIXED    = 3'd3;
  localparam logic [2:0] ERR_PARITY   = 3'd4;
  localparam logic [2:0] ERR_LOSS     = 3'd5;

  // Second numbers inside the minute; P1..P3 are the even-parity bits.
  localparam int BIT_START      = 0;
  localparam int BIT_TIME_START = 20;
  localparam int BIT_P1         = 28;
  localparam int BIT_P2         = 35;
  localparam int BIT_P3         = 58;

endpackage

// File: rtl/dcf77_frame_checker.sv
// Combinational sanity check of an assembled DCF77 frame: fixed bits first, then the
// three even-parity groups. Used only when DCF77_FRAME_CHECK_EN is defined.
module dcf77_frame_checker
  import dcf77_pkg::*;
(
  input  logic [58:0] frame_in,
  output logic        pass_out,
  output logic [2:0]  code_out
);

  logic fixed_ok;
  logic parity_ok;

  always_comb begin
    fixed_ok  = (frame_in[BIT_START] == 1'b0) && frame_in[BIT_TIME_START];
    parity_ok = !(^frame_in[BIT_P1:BIT_TIME_START+1]) &&
                !(^frame_in[BIT_P2:BIT_P1+1]) &&
                !(^frame_in[BIT_P3:BIT_P2+1]);
    pass_out  = fixed_ok && parity_ok;
    code_out  = ERR_NONE;
    if (!fixed_ok) begin
      code_out = ERR_FIXED;
    end else if (!parity_ok) begin
      code_out = ERR_PARITY;
    end
  end

endmodule

// File: rtl/dcf77_frame_controller.sv
// Sequences the external 59-bit DCF77 shift register from decoded bit strobes and
// latches validated frames. Define DCF77_FRAME_CHECK_EN to enable fixed-bit/parity checks.
module dcf77_frame_controller
  import dcf77_pkg::*;
#(
  parameter int GAP_TICKS  = 1500,
  parameter int LOSS_TICKS = 3000,
  parameter int CNT_W      = 12
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tick_in,
  input  logic        bit_valid_in,
  input  logic        bit_in,
  input  logic [58:0] sr_parallel_in,
  output logic        sr_shift_out,
  output logic        sr_bit_out,
  output logic        sr_clear_out,
  output logic [58:0] frame_out,
  output logic        frame_valid_out,
  output logic        sync_out,
  output logic [5:0]  bit_cnt_out,
  output logic        err_out,
  output logic [2:0]  err_code_out
);

  localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] LOSS_M1  = CNT_W'(LOSS_TICKS - 1);
  localparam logic [CNT_W-1:0] LOSS_CNT = CNT_W'(LOSS_TICKS);
  localparam logic [5:0]       FULL_CNT = 6'(FRAME_BITS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             sr_shift_q, sr_shift_d;
  logic             sr_bit_q, sr_bit_d;
  logic             sr_clear_q, sr_clear_d;
  logic [58:0]      frame_q, frame_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_q, sync_d;
  logic             err_q, err_d;
  logic [2:0]       err_code_q, err_code_d;

  logic             marker_evt, loss_evt;
  logic             chk_pass;
  logic [2:0]       chk_code;

`ifdef DCF77_FRAME_CHECK_EN
  dcf77_frame_checker u_checker (
    .frame_in (sr_parallel_in),
    .pass_out (chk_pass),
    .code_out (chk_code)
  );
`else
  assign chk_pass = 1'b1;
  assign chk_code = ERR_NONE;
`endif

  // Events fire only on the tick that steps the counter onto the threshold,
  // so each is a single-cycle condition even while the count stays there.
  always_comb begin
    gap_d      = gap_q;
    marker_evt = 1'b0;
    loss_evt   = 1'b0;
    if (bit_valid_in) begin
      gap_d = '0;
    end else if (tick_in && (gap_q != LOSS_CNT)) begin
      gap_d      = gap_q + 1'b1;
      marker_evt = (gap_q == GAP_M1);
      loss_evt   = (gap_q == LOSS_M1);
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    sr_shift_d    = 1'b0;
    sr_bit_d      = 1'b0;
    sr_clear_d    = 1'b0;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    if (loss_evt && (state_q != SYNC_WAIT)) begin
      err_d      = 1'b1;
      err_code_d = ERR_LOSS;
      bit_cnt_d  = '0;
      state_d    = SYNC_WAIT;
    end else begin
      unique case (state_q)
        SYNC_WAIT: begin
          if (marker_evt) begin
            sr_clear_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = RECEIVE;
          end
        end
        RECEIVE: begin
          if (marker_evt) begin
            if (bit_cnt_q == FULL_CNT) begin
              state_d = CHECK;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_SHORT;
              sr_clear_d = 1'b1;
              bit_cnt_d  = '0;
            end
          end else if (bit_valid_in) begin
            if (bit_cnt_q == FULL_CNT) begin
              err_d      = 1'b1;
              err_code_d = ERR_OVERFLOW;
              sr_clear_d = 1'b1;
              bit_cnt_d  = '0;
              state_d    = SYNC_WAIT;
            end else begin
              sr_shift_d = 1'b1;
              sr_bit_d   = bit_in;
              bit_cnt_d  = bit_cnt_q + 6'd1;
            end
          end
        end
        CHECK: begin
          if (chk_pass) begin
            frame_d       = sr_parallel_in;
            frame_valid_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = chk_code;
          end
          sr_clear_d = 1'b1;
          bit_cnt_d  = '0;
          state_d    = RECEIVE;
        end
        default: state_d = SYNC_WAIT;
      endcase
    end
    sync_d = (state_d != SYNC_WAIT);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= SYNC_WAIT;
      gap_q         <= '0;
      bit_cnt_q     <= '0;
      sr_shift_q    <= 1'b0;
      sr_bit_q      <= 1'b0;
      sr_clear_q    <= 1'b0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      sync_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      bit_cnt_q     <= bit_cnt_d;
      sr_shift_q    <= sr_shift_d;
      sr_bit_q      <= sr_bit_d;
      sr_clear_q    <= sr_clear_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      sync_q        <= sync_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign sr_shift_out    = sr_shift_q;
  assign sr_bit_out      = sr_bit_q;
  assign sr_clear_out    = sr_clear_q;
  assign frame_out       = frame_q;
  assign frame_valid_out = frame_valid_q;
  assign sync_out        = sync_q;
  assign bit_cnt_out     = bit_cnt_q;
  assign err_out         = err_q;
  assign err_code_out    = err_code_q;

endmodule

// File: tb/tb_dcf77_frame_controller.sv
// Scoreboard bench for dcf77_frame_controller with shortened gap/loss thresholds.
module tb_dcf77_frame_controller;

  localparam int GAP  = 20;
  localparam int LOSS = 40;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        tick_in = 1'b0;
  logic        bit_valid_in = 1'b0;
  logic        bit_in = 1'b0;
  logic [58:0] sr_parallel_in;
  logic        sr_shift_out, sr_bit_out, sr_clear_out;
  logic [58:0] frame_out;
  logic        frame_valid_out, sync_out, err_out;
  logic [5:0]  bit_cnt_out;
  logic [2:0]  err_code_out;

  dcf77_frame_controller #(.GAP_TICKS(GAP), .LOSS_TICKS(LOSS), .CNT_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tick_in(tick_in), .bit_valid_in(bit_valid_in),
    .bit_in(bit_in), .sr_parallel_in(sr_parallel_in), .sr_shift_out(sr_shift_out),
    .sr_bit_out(sr_bit_out), .sr_clear_out(sr_clear_out), .frame_out(frame_out),
    .frame_valid_out(frame_valid_out), .sync_out(sync_out), .bit_cnt_out(bit_cnt_out),
    .err_out(err_out), .err_code_out(err_code_out)
  );

  always #5 clk_in = ~clk_in;

  // External shift register: first bit received ends up at [0].
  logic [58:0] sr_model = '0;
  always @(posedge clk_in) begin
    if (rst_in || sr_clear_out) sr_model <= '0;
    else if (sr_shift_out)      sr_model <= {sr_bit_out, sr_model[58:1]};
  end
  assign sr_parallel_in = sr_model;

  int n_checks = 0;
  int n_fail = 0;
  int n_shift = 0, n_fv = 0, n_err = 0, n_clear = 0;

  logic        shift_q[$];
  logic [58:0] frame_q[$];
  logic [2:0]  err_q[$];
  logic        mon_b;
  logic [58:0] mon_f;
  logic [2:0]  mon_c;

  logic        exp_sync = 1'b0;
  int          exp_cnt = 0;
  logic [58:0] cur_frame = '0;

  // Output monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (sr_shift_out) begin
        n_shift++;
        n_checks++;
        if (shift_q.size() == 0) begin
          n_fail++;
          $display("FAIL shift_unexpected: got sr_shift_out=1 bit=%0b, no shift expected", sr_bit_out);
        end else begin
          mon_b = shift_q.pop_front();
          if (sr_bit_out !== mon_b) begin
            n_fail++;
            $display("FAIL shift_bit: got %0b, expected %0b", sr_bit_out, mon_b);
          end
        end
      end
      if (frame_valid_out) begin
        n_fv++;
        n_checks++;
        if (frame_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_unexpected: got frame_valid_out with frame %h, none expected", frame_out);
        end else begin
          mon_f = frame_q.pop_front();
          if (frame_out !== mon_f) begin
            n_fail++;
            $display("FAIL frame_value: got %h, expected %h", frame_out, mon_f);
          end
        end
      end
      if (err_out) begin
        n_err++;
        n_checks++;
        if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL err_unexpected: got err_out with code %0d, no error expected", err_code_out);
        end else begin
          mon_c = err_q.pop_front();
          if (err_code_out !== mon_c) begin
            n_fail++;
            $display("FAIL err_code: got %0d, expected %0d", err_code_out, mon_c);
          end
        end
      end
      if (frame_valid_out && err_out) begin
        n_checks++;
        n_fail++;
        $display("FAIL fv_err_overlap: got both frame_valid_out and err_out high, expected exclusive");
      end
      if (sr_clear_out) n_clear++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test after 400000 ns, expected completion");
    $fatal(1, "timeout");
  end

  task automatic step(input logic t, input logic bv, input logic b);
    tick_in = t;
    bit_valid_in = bv;
    bit_in = b;
    @(posedge clk_in);
    #1;
    tick_in = 1'b0;
    bit_valid_in = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_bit(input logic b, input logic with_tick);
    if (exp_sync) begin
      if (exp_cnt < 59) begin
        shift_q.push_back(b);
        exp_cnt++;
      end else begin
        err_q.push_back(3'd2);
        exp_sync = 1'b0;
        exp_cnt = 0;
      end
    end
    step(with_tick, 1'b1, b);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Expects the gap counter to be 0 on entry (preceded by a bit or reset).
  task automatic marker(input logic [2:0] chk_code);
    if (!exp_sync) begin
      exp_sync = 1'b1;
    end else if (exp_cnt == 59) begin
      if (chk_code == 3'd0) frame_q.push_back(cur_frame);
      else                  err_q.push_back(chk_code);
    end else begin
      err_q.push_back(3'd1);
    end
    exp_cnt = 0;
    tick_n(GAP);
    idle(3);
  endtask

  task automatic send_frame(input logic [58:0] f, input logic [2:0] chk_code);
    cur_frame = f;
    for (int k = 0; k < 59; k++) send_bit(f[k], (k % 7) == 3);
    marker(chk_code);
  endtask

  function automatic logic [58:0] make_frame(input int unsigned seed);
    logic [58:0] f;
    logic [31:0] s;
    s = seed * 32'h9E3779B1;
    f = {27'(s ^ 32'h2A5C1), s ^ 32'h5A5AC3C3};
    f[0]  = 1'b0;
    f[20] = 1'b1;
    f[28] = ^f[27:21];
    f[35] = ^f[34:29];
    f[58] = ^f[57:36];
    return f;
  endfunction

  task automatic do_reset();
    rst_in = 1'b1;
    idle(3);
    rst_in = 1'b0;
    shift_q.delete();
    frame_q.delete();
    err_q.delete();
    exp_sync = 1'b0;
    exp_cnt = 0;
    idle(1);
  endtask

  task automatic queues_empty(input string name);
    n_checks++;
    if (shift_q.size() + frame_q.size() + err_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: got %0d shifts %0d frames %0d errors outstanding, expected 0",
               name, shift_q.size(), frame_q.size(), err_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({sr_shift_out, sr_bit_out, sr_clear_out, frame_valid_out, err_out, sync_out} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, expected 000000",
               {sr_shift_out, sr_bit_out, sr_clear_out, frame_valid_out, err_out, sync_out});
    end
    n_checks++;
    if (frame_out !== 59'd0 || bit_cnt_out !== 6'd0 || err_code_out !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got frame=%h cnt=%0d code=%0d, expected all 0",
               frame_out, bit_cnt_out, err_code_out);
    end
  endtask

  task automatic test_valid_frame();
    int c0, s0, f0;
    logic [58:0] f;
    f = make_frame(1);
    c0 = n_clear;
    marker(3'd0);
    n_checks++;
    if (sync_out !== 1'b1 || n_clear - c0 !== 1) begin
      n_fail++;
      $display("FAIL sync_marker: got sync=%0b clears=%0d, expected 1 and 1", sync_out, n_clear - c0);
    end
    s0 = n_shift;
    f0 = n_fv;
    send_frame(f, 3'd0);
    n_checks++;
    if (n_shift - s0 !== 59 || n_fv - f0 !== 1) begin
      n_fail++;
      $display("FAIL valid_counts: got shifts=%0d frame_valids=%0d, expected 59 and 1",
               n_shift - s0, n_fv - f0);
    end
    n_checks++;
    if (frame_out !== f || sync_out !== 1'b1 || bit_cnt_out !== 6'd0) begin
      n_fail++;
      $display("FAIL valid_frame: got frame=%h sync=%0b cnt=%0d, expected %h 1 0",
               frame_out, sync_out, bit_cnt_out, f);
    end
    queues_empty("valid_frame");
  endtask

  task automatic test_short_frame();
    int c0;
    logic [58:0] f;
    f = make_frame(2);
    c0 = n_clear;
    for (int k = 0; k < 58; k++) send_bit(f[k], 1'b0);
    marker(3'd0);
    n_checks++;
    if (err_code_out !== 3'd1 || sync_out !== 1'b1 || n_clear - c0 !== 1) begin
      n_fail++;
      $display("FAIL short_frame: got code=%0d sync=%0b clears=%0d, expected 1 1 1",
               err_code_out, sync_out, n_clear - c0);
    end
    send_frame(f, 3'd0);
    n_checks++;
    if (frame_out !== f) begin
      n_fail++;
      $display("FAIL after_short: got %h, expected %h", frame_out, f);
    end
    queues_empty("short_frame");
  endtask

  task automatic test_check_fail();
    logic [58:0] good, bad;
    logic [2:0] code;
    good = frame_out;
    bad = good;
    bad[28] = ~bad[28];
`ifdef DCF77_FRAME_CHECK_EN
    code = 3'd4;
`else
    code = 3'd0;
`endif
    send_frame(bad, code);
    n_checks++;
    if (frame_out !== ((code == 3'd0) ? bad : good)) begin
      n_fail++;
      $display("FAIL parity_frame: got %h, expected %h", frame_out, (code == 3'd0) ? bad : good);
    end
    good = frame_out;
    bad = good;
    bad[20] = 1'b0;
`ifdef DCF77_FRAME_CHECK_EN
    code = 3'd3;
    n_checks++;
    if (err_code_out !== 3'd4) begin
      n_fail++;
      $display("FAIL parity_code: got %0d, expected 4", err_code_out);
    end
`else
    code = 3'd0;
`endif
    send_frame(bad, code);
    n_checks++;
    if (frame_out !== ((code == 3'd0) ? bad : good)) begin
      n_fail++;
      $display("FAIL fixed_frame: got %h, expected %h", frame_out, (code == 3'd0) ? bad : good);
    end
`ifdef DCF77_FRAME_CHECK_EN
    n_checks++;
    if (err_code_out !== 3'd3) begin
      n_fail++;
      $display("FAIL fixed_code: got %0d, expected 3", err_code_out);
    end
`endif
    queues_empty("check_fail");
  endtask

  task automatic test_overflow();
    logic [58:0] f;
    f = make_frame(3);
    for (int k = 0; k < 59; k++) send_bit(f[k], 1'b0);
    send_bit(1'b1, 1'b0);
    idle(2);
    n_checks++;
    if (err_code_out !== 3'd2 || sync_out !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow: got code=%0d sync=%0b, expected 2 0", err_code_out, sync_out);
    end
    marker(3'd0);
    n_checks++;
    if (sync_out !== 1'b1) begin
      n_fail++;
      $display("FAIL resync: got sync=%0b, expected 1", sync_out);
    end
    queues_empty("overflow");
  endtask

  task automatic test_loss();
    int e0;
    // The marker that preceded this left the gap counter at GAP.
    err_q.push_back(3'd5);
    exp_sync = 1'b0;
    exp_cnt = 0;
    tick_n(LOSS - GAP);
    idle(2);
    n_checks++;
    if (err_code_out !== 3'd5 || sync_out !== 1'b0) begin
      n_fail++;
      $display("FAIL loss: got code=%0d sync=%0b, expected 5 0", err_code_out, sync_out);
    end
    e0 = n_err;
    tick_n(10);
    n_checks++;
    if (n_err - e0 !== 0 || sync_out !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_repeat: got %0d errors sync=%0b, expected 0 0", n_err - e0, sync_out);
    end
    send_bit(1'b0, 1'b0);
    marker(3'd0);
    queues_empty("loss");
  endtask

  task automatic test_coincide();
    int e0;
    send_bit(1'b1, 1'b0);
    tick_n(GAP - 1);
    send_bit(1'b0, 1'b1);
    e0 = n_err;
    tick_n(GAP - 1);
    n_checks++;
    if (n_err - e0 !== 0 || bit_cnt_out !== 6'd2 || sync_out !== 1'b1) begin
      n_fail++;
      $display("FAIL coincide: got errors=%0d cnt=%0d sync=%0b, expected 0 2 1",
               n_err - e0, bit_cnt_out, sync_out);
    end
    err_q.push_back(3'd1);
    exp_cnt = 0;
    tick_n(1);
    idle(2);
    n_checks++;
    if (err_code_out !== 3'd1 || bit_cnt_out !== 6'd0) begin
      n_fail++;
      $display("FAIL coincide_marker: got code=%0d cnt=%0d, expected 1 0", err_code_out, bit_cnt_out);
    end
    queues_empty("coincide");
  endtask

  task automatic test_reset_mid();
    logic [58:0] f;
    f = make_frame(5);
    for (int k = 0; k < 30; k++) send_bit(f[k], 1'b0);
    n_checks++;
    if (bit_cnt_out !== 6'd30) begin
      n_fail++;
      $display("FAIL mid_count: got %0d, expected 30", bit_cnt_out);
    end
    do_reset();
    n_checks++;
    if (frame_out !== 59'd0 || bit_cnt_out !== 6'd0 || err_code_out !== 3'd0 || sync_out !== 1'b0 ||
        {sr_shift_out, sr_bit_out, sr_clear_out, frame_valid_out, err_out} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got frame=%h cnt=%0d code=%0d sync=%0b, expected all 0",
               frame_out, bit_cnt_out, err_code_out, sync_out);
    end
    marker(3'd0);
    send_frame(f, 3'd0);
    n_checks++;
    if (frame_out !== f) begin
      n_fail++;
      $display("FAIL reset_recover: got %h, expected %h", frame_out, f);
    end
    queues_empty("reset_mid");
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_short_frame();
    test_check_fail();
    test_overflow();
    test_loss();
    test_coincide();
    test_reset_mid();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
